// File: rtl/img_deci_frame_ctrl.sv
// img_deci_frame_ctrl: frame sequencer gating a valid/ready stream into the 2x2 decimator, counting beats per frame.
// Optional drain watchdog enabled by defining IMG_DECI_FRAME_CTRL_TIMEOUT_EN.
module img_deci_frame_ctrl #(
  parameter int IMG_WIDTH   = 2048,
  parameter int IMG_HEIGHT  = 2048,
  parameter int TIMEOUT_CYC = 4096
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clr_err,
  input  logic [63:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [63:0] deci_din,
  output logic        deci_din_valid,
  output logic        deci_frame_start,
  input  logic        deci_dout_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] frame_cnt,
  output logic [23:0] in_beat_cnt,
  output logic [23:0] out_beat_cnt
);
  localparam int LINE_BEATS = IMG_WIDTH / 8;
  localparam int IN_BEATS   = LINE_BEATS * IMG_HEIGHT;
  localparam int OUT_BEATS  = LINE_BEATS * IMG_HEIGHT / 2;
  typedef enum logic [2:0] {IDLE, SOF, RUN, DRAIN, DONE, ERR} state_t;
  state_t state, state_nx;
  logic accept, strobe, last_in, out_full, tmo;
  assign s_ready          = state == RUN;
  assign deci_frame_start = state == SOF;
  assign busy             = state != IDLE;
  assign done             = state == DONE;
  assign err              = state == ERR;
  assign accept           = s_valid & s_ready;
  assign strobe           = deci_dout_valid & (state == RUN || state == DRAIN);
  assign last_in          = accept & (in_beat_cnt == 24'(IN_BEATS - 1));
  assign out_full         = out_beat_cnt == 24'(OUT_BEATS);
`ifdef IMG_DECI_FRAME_CTRL_TIMEOUT_EN
  logic [15:0] wd;
  // held at zero outside DRAIN, so entering DRAIN always starts from a clean count
  always_ff @(posedge clk or posedge rst)
    if (rst) wd <= '0;
    else wd <= (state == DRAIN && !deci_dout_valid) ? wd + 16'd1 : '0;
  assign tmo = !deci_dout_valid && wd == 16'(TIMEOUT_CYC - 1);
`else
  assign tmo = TIMEOUT_CYC < 0;
`endif
  // an extra output strobe beats both drain completion and the watchdog
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? SOF : IDLE;
      SOF:     state_nx = RUN;
      RUN:     state_nx = (strobe && out_full) ? ERR : last_in ? DRAIN : RUN;
      DRAIN:   state_nx = (strobe && out_full) ? ERR : out_full ? DONE : tmo ? ERR : DRAIN;
      DONE:    state_nx = IDLE;
      ERR:     state_nx = clr_err ? IDLE : ERR;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      deci_din       <= '0;
      deci_din_valid <= 1'b0;
      frame_cnt      <= '0;
      in_beat_cnt    <= '0;
      out_beat_cnt   <= '0;
    end else begin
      state          <= state_nx;
      deci_din_valid <= accept;
      if (accept) deci_din <= s_data;
      if (state == IDLE && start) begin
        in_beat_cnt  <= '0;
        out_beat_cnt <= '0;
      end
      if (accept) in_beat_cnt <= in_beat_cnt + 24'd1;
      if (strobe && !out_full) out_beat_cnt <= out_beat_cnt + 24'd1;
      if (state == DONE) frame_cnt <= frame_cnt + 16'd1;
    end
endmodule

// File: tb/tb_img_deci_frame_ctrl.sv
// tb_img_deci_frame_ctrl: directed bench for the frame sequencer on a 32x4 frame (16 input beats, 8 output beats).
module tb_img_deci_frame_ctrl;
  localparam int W = 32, H = 4, T = 64, IN = 16, OUT = 8;
  logic clk = 0, rst = 1, start = 0, clr_err = 0, s_valid = 0, deci_dout_valid = 0;
  logic s_ready, deci_din_valid, deci_frame_start, busy, done, err;
  logic [63:0] s_data = '0, deci_din;
  logic [15:0] frame_cnt;
  logic [23:0] in_beat_cnt, out_beat_cnt;
  int checks = 0, errors = 0, fs_cnt = 0, dv_cnt = 0, done_cnt = 0, dv_mis = 0;
  logic acc_prev = 0;
  logic [63:0] got[$], exp_q[$];
  logic [15:0] tag = 0;
  always #5 clk = ~clk;
  img_deci_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .start(start), .clr_err(clr_err), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .deci_din(deci_din), .deci_din_valid(deci_din_valid),
    .deci_frame_start(deci_frame_start), .deci_dout_valid(deci_dout_valid), .busy(busy),
    .done(done), .err(err), .frame_cnt(frame_cnt), .in_beat_cnt(in_beat_cnt), .out_beat_cnt(out_beat_cnt));
  // inputs change just after posedge, so at negedge s_valid&s_ready is what the next edge accepts
  always @(negedge clk)
    if (rst) begin
      fs_cnt = 0; dv_cnt = 0; done_cnt = 0; dv_mis = 0; acc_prev = 0; got.delete();
    end else begin
      if (deci_frame_start) fs_cnt++;
      if (deci_din_valid) begin dv_cnt++; got.push_back(deci_din); end
      if (deci_din_valid !== acc_prev) dv_mis++;
      if (done) done_cnt++;
      acc_prev = s_valid & s_ready;
    end
  task automatic cyc; @(posedge clk); #2; endtask
  task automatic do_reset;
    rst = 1; start = 0; clr_err = 0; s_valid = 0; deci_dout_valid = 0; exp_q.delete();
    repeat (2) cyc;
    rst = 0;
    cyc;
  endtask
  task automatic pulse_start; start = 1; cyc; start = 0; tag++; endtask
  task automatic send_beats(input int n, input bit thr, output bit ok);
    int sent = 0;
    bit tog = 1;
    for (int g = 0; g < 4 * n + 8 && sent < n; g++) begin
      s_valid = thr ? tog : 1'b1;
      tog = ~tog;
      s_data = {tag, 16'hBEEF, 32'(sent)};
      if (s_valid && s_ready) begin exp_q.push_back(s_data); sent++; end
      cyc;
    end
    s_valid = 0;
    ok = sent == n;
  endtask
  task automatic send_strobes(input int n);
    repeat (n) begin deci_dout_valid = 1; cyc; end
    deci_dout_valid = 0;
  endtask
  function automatic bit data_ok();
    if (got.size() != exp_q.size()) return 0;
    foreach (got[i]) if (got[i] !== exp_q[i]) return 0;
    return 1;
  endfunction
  task automatic test_reset;
    do_reset;
    checks++; if ({busy, s_ready, done, err, deci_frame_start, deci_din_valid} !== 6'b0) begin errors++; $display("FAIL rst_flags got=%b exp=000000", {busy, s_ready, done, err, deci_frame_start, deci_din_valid}); end
    checks++; if ({frame_cnt, in_beat_cnt, out_beat_cnt} !== 64'd0) begin errors++; $display("FAIL rst_counts got=%h/%h/%h exp=0", frame_cnt, in_beat_cnt, out_beat_cnt); end
    checks++; if (deci_din !== 64'd0) begin errors++; $display("FAIL rst_din got=%h exp=0", deci_din); end
  endtask
  task automatic test_frame(input bit thr);
    bit ok;
    do_reset;
    pulse_start;
    checks++; if ({deci_frame_start, busy, s_ready} !== 3'b110) begin errors++; $display("FAIL sof_flags thr=%0b got=%b exp=110", thr, {deci_frame_start, busy, s_ready}); end
    send_beats(IN, thr, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL beats_timeout thr=%0b got=%0b exp=1", thr, ok); end
    checks++; if (in_beat_cnt !== 24'd16 || s_ready !== 1'b0) begin errors++; $display("FAIL drain_entry thr=%0b in=%0d rdy=%0b exp 16/0", thr, in_beat_cnt, s_ready); end
    send_strobes(OUT);
    checks++; if (out_beat_cnt !== 24'd8 || done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL drain_full thr=%0b out=%0d done=%0b busy=%0b exp 8/0/1", thr, out_beat_cnt, done, busy); end
    cyc;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_pulse thr=%0b got=%0b exp=1", thr, done); end
    cyc;
    checks++; if ({done, busy} !== 2'b00 || frame_cnt !== 16'd1) begin errors++; $display("FAIL frame_end thr=%0b done=%0b busy=%0b fc=%0d exp 0/0/1", thr, done, busy, frame_cnt); end
    checks++; if (fs_cnt !== 1 || dv_cnt !== 16 || done_cnt !== 1) begin errors++; $display("FAIL pulse_counts thr=%0b fs=%0d dv=%0d done=%0d exp 1/16/1", thr, fs_cnt, dv_cnt, done_cnt); end
    checks++; if (dv_mis !== 0) begin errors++; $display("FAIL din_valid_timing thr=%0b got=%0d exp=0", thr, dv_mis); end
    checks++; if (data_ok() !== 1'b1) begin errors++; $display("FAIL data_order thr=%0b got=%0d beats exp=%0d", thr, got.size(), exp_q.size()); end
    send_strobes(3);
    checks++; if (out_beat_cnt !== 24'd8 || err !== 1'b0) begin errors++; $display("FAIL idle_strobes thr=%0b out=%0d err=%0b exp 8/0", thr, out_beat_cnt, err); end
  endtask
  task automatic test_ignored_start;
    bit ok;
    do_reset;
    pulse_start;
    send_beats(8, 0, ok);
    start = 1; cyc; start = 0;
    checks++; if (s_ready !== 1'b1 || deci_frame_start !== 1'b0 || in_beat_cnt !== 24'd8) begin errors++; $display("FAIL start_in_run rdy=%0b fs=%0b in=%0d exp 1/0/8", s_ready, deci_frame_start, in_beat_cnt); end
    send_beats(8, 0, ok);
    send_strobes(OUT);
    cyc;
    start = 1; cyc; start = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done busy=%0b exp=0", busy); end
    cyc;
    checks++; if (busy !== 1'b0 || frame_cnt !== 16'd1 || fs_cnt !== 1) begin errors++; $display("FAIL one_frame busy=%0b fc=%0d fs=%0d exp 0/1/1", busy, frame_cnt, fs_cnt); end
  endtask
  task automatic test_overflow;
    bit ok;
    do_reset;
    pulse_start;
    send_beats(IN, 0, ok);
    send_strobes(OUT + 1);
    checks++; if ({err, busy} !== 2'b11 || done_cnt !== 0) begin errors++; $display("FAIL ovf_err err=%0b busy=%0b done=%0d exp 1/1/0", err, busy, done_cnt); end
    send_strobes(1);
    checks++; if (out_beat_cnt !== 24'd8 || in_beat_cnt !== 24'd16) begin errors++; $display("FAIL err_frozen out=%0d in=%0d exp 8/16", out_beat_cnt, in_beat_cnt); end
    start = 1; cyc; start = 0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL start_in_err err=%0b exp=1", err); end
    start = 1; clr_err = 1; cyc; start = 0; clr_err = 0;
    checks++; if ({err, busy} !== 2'b00) begin errors++; $display("FAIL clr_err err=%0b busy=%0b exp 0/0", err, busy); end
    cyc;
    checks++; if ({deci_frame_start, busy} !== 2'b00) begin errors++; $display("FAIL clr_only fs=%0b busy=%0b exp 0/0", deci_frame_start, busy); end
    pulse_start;
    send_beats(IN, 0, ok);
    send_strobes(OUT);
    repeat (3) cyc;
    checks++; if (frame_cnt !== 16'd1 || {err, busy} !== 2'b00 || done_cnt !== 1) begin errors++; $display("FAIL after_err fc=%0d err=%0b busy=%0b done=%0d exp 1/0/0/1", frame_cnt, err, busy, done_cnt); end
  endtask
  task automatic test_short_drain;
    bit ok;
    do_reset;
    pulse_start;
    send_beats(IN, 0, ok);
    send_strobes(OUT - 1);
`ifdef IMG_DECI_FRAME_CTRL_TIMEOUT_EN
    repeat (T - 1) cyc;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_early err=%0b exp=0", err); end
    cyc;
    checks++; if (err !== 1'b1 || done_cnt !== 0) begin errors++; $display("FAIL wd_fire err=%0b done=%0d exp 1/0", err, done_cnt); end
`else
    repeat (100) cyc;
    checks++; if ({busy, err} !== 2'b10 || done_cnt !== 0 || out_beat_cnt !== 24'd7) begin errors++; $display("FAIL drain_wait busy=%0b err=%0b done=%0d out=%0d exp 1/0/0/7", busy, err, done_cnt, out_beat_cnt); end
`endif
  endtask
  task automatic test_reset_mid_frame;
    bit ok;
    do_reset;
    pulse_start;
    send_beats(5, 0, ok);
    checks++; if (in_beat_cnt !== 24'd5 || deci_din_valid !== 1'b1) begin errors++; $display("FAIL pre_rst in=%0d dv=%0b exp 5/1", in_beat_cnt, deci_din_valid); end
    rst = 1;
    #1;
    checks++; if ({busy, s_ready, deci_din_valid, deci_frame_start, done, err} !== 6'b0) begin errors++; $display("FAIL async_rst_flags got=%b exp=000000", {busy, s_ready, deci_din_valid, deci_frame_start, done, err}); end
    checks++; if (in_beat_cnt !== 24'd0 || deci_din !== 64'd0) begin errors++; $display("FAIL async_rst_data in=%0d din=%h exp 0/0", in_beat_cnt, deci_din); end
    cyc; cyc;
    rst = 0; exp_q.delete();
    cyc;
    pulse_start;
    send_beats(IN, 0, ok);
    send_strobes(OUT);
    repeat (2) cyc;
    checks++; if (frame_cnt !== 16'd1 || fs_cnt !== 1 || dv_cnt !== 16 || busy !== 1'b0) begin errors++; $display("FAIL post_rst_frame fc=%0d fs=%0d dv=%0d busy=%0b exp 1/1/16/0", frame_cnt, fs_cnt, dv_cnt, busy); end
    checks++; if (data_ok() !== 1'b1) begin errors++; $display("FAIL post_rst_data got=%0d beats exp=%0d", got.size(), exp_q.size()); end
  endtask
  initial begin
    test_reset;
    test_frame(0);
    test_frame(1);
    test_ignored_start;
    test_overflow;
    test_short_drain;
    test_reset_mid_frame;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
